muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  input  1  request from EX stage; sampled only in IDLE.
REQ-004 SHALL have port funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port op_a  input  32  rs1 operand, or dividend.
REQ-006 SHALL have port op_b  input  32  rs2 operand, or divisor.
REQ-007 SHALL have port flush  input  1  pipeline flush; aborts the current operation.
REQ-008 SHALL have port stall  output  1  freezes IF/ID/EX while the operation is in progress.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  single-cycle pulse; result is valid in that cycle.
REQ-011 SHALL have port result  output  32  operation result; holds its value until the next accepted start.

Function
REQ-012 SHALL implement an FSM with states IDLE, PREP, ITER, FIX and DONE.
REQ-013 IDLE: start=1 SHALL latch funct3, op_a and op_b and go to PREP; start=0 stays in IDLE.
REQ-014 PREP SHALL record operand signs according to funct3 (MULHSU: op_a signed, op_b unsigned; U ops: both unsigned), take magnitudes, clear the 64-bit accumulator and the 6-bit counter, then go to ITER.
REQ-015 ITER SHALL perform 32 cycles: shift-add for multiply, restoring shift-subtract for divide; one bit per cycle; counter 0..31; go to FIX when the counter reaches 31.
REQ-016 FIX SHALL negate per the recorded signs and select the output: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; quotient for DIV/DIVU; remainder for REM/REMU. A signed remainder takes the sign of the dividend. FIX then goes to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, drive result, and return to IDLE.
REQ-018 Latency: a start sampled at cycle 0 SHALL produce done in cycle 35.
REQ-019 Divide by zero (op_b=0, DIV/DIVU/REM/REMU) SHALL go PREP->DONE with done in cycle 2: quotient 0xFFFFFFFF, remainder = op_a.
REQ-020 Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF) SHALL go PREP->DONE with done in cycle 2: quotient 0x80000000, remainder 0.
REQ-021 stall SHALL equal (start AND state==IDLE) OR state in {PREP, ITER, FIX}, and SHALL be low in DONE.
REQ-022 start asserted while busy SHALL be ignored, with no effect on latched operands.
REQ-023 flush=1 in any non-IDLE state SHALL force IDLE at the next edge, with no done pulse and result unchanged.
REQ-024 flush and start asserted together in IDLE SHALL result in the start being ignored.
REQ-025 All arithmetic SHALL be performed modulo 2^32 per the RV32M definitions.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, stall=0, busy=0, done=0, result=0x00000000, accumulator and counter to 0.
REQ-027 Reset asserted mid-operation SHALL discard the operation; after release the block waits in IDLE for a new start.

Structure
REQ-028 The shared package muldiv_pkg SHALL hold the funct3 op codes, the FSM state encoding and the constant ITER_COUNT=32.
REQ-029 The sign/negate/select logic of FIX SHALL be one combinational sub-module, muldiv_signfix; the FSM and iteration datapath SHALL remain in muldiv_sequencer.

Verification
REQ-030 MUL op_a=7, op_b=0xFFFFFFFD, start at cycle 0 -> stall high in cycles 0-34, done in cycle 35, result 0xFFFFFFEB.
REQ-031 MULH 0x80000000*0x80000000 -> result 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 DIVU 5/0 -> done in cycle 2, result 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> done in cycle 2, result 0x80000000.
REQ-034 Start a MUL, assert flush in cycle 10 -> IDLE in cycle 11, no done, result unchanged; a start during cycles 1-34 of another op is ignored.
REQ-035 Drive rst=0 asynchronously in cycle 20 of a DIV -> all outputs 0 immediately; after release a new MUL 3*4 -> result 12 in cycle 35.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: op codes, FSM
// encoding, iteration count and operand-signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int ITER_COUNT = 32;

  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  // MULHSU treats rs2 as unsigned; divides are signed only for DIV/REM.
  function automatic logic b_is_signed(input logic [2:0] f3);
    return f3[2] ? !f3[0] : !f3[1];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final sign correction and result selection applied to the unsigned
// magnitude product / quotient-remainder pair left by the iteration.
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] acc,
  input  logic        sign_a,
  input  logic        sign_b,
  output logic [31:0] result
);

  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    prod = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
    quot = (sign_a ^ sign_b) ? (~acc[31:0] + 32'd1) : acc[31:0];
    // Remainder follows the dividend's sign only.
    rem  = sign_a ? (~acc[63:32] + 32'd1) : acc[63:32];
    case (funct3)
      F3_MUL:          result = prod[31:0];
      F3_DIV, F3_DIVU: result = quot;
      F3_REM, F3_REMU: result = rem;
      default:         result = prod[63:32];
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply
// and restoring divide, with early exit for divide-by-zero and overflow.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  logic [2:0]  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  logic [31:0] fix_result;
  logic [4:0]  bit_idx;
  logic [32:0] rem_shift;
  logic [31:0] rem_diff;

  muldiv_signfix u_signfix (
    .funct3 (f3_q),
    .acc    (acc_q),
    .sign_a (sign_a_q),
    .sign_b (sign_b_q),
    .result (fix_result)
  );

  // Operands are consumed MSB first so both algorithms shift left.
  assign bit_idx   = 5'd31 - cnt_q[4:0];
  assign rem_shift = {acc_q[63:32], a_q[bit_idx]};
  assign rem_diff  = rem_shift[31:0] - b_q;

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          f3_d    = funct3;
          a_d     = op_a;
          b_d     = op_b;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        sign_a_d = a_is_signed(f3_q) && a_q[31];
        sign_b_d = b_is_signed(f3_q) && b_q[31];
        a_d      = sign_a_d ? (~a_q + 32'd1) : a_q;
        b_d      = sign_b_d ? (~b_q + 32'd1) : b_q;
        acc_d    = 64'd0;
        cnt_d    = 6'd0;
        state_d  = ST_ITER;
        if (f3_q[2] && (b_q == 32'd0)) begin
          result_d = f3_q[1] ? a_q : 32'hFFFF_FFFF;
          state_d  = ST_DONE;
        end else if (f3_q[2] && !f3_q[0] && (a_q == 32'h8000_0000) &&
                     (b_q == 32'hFFFF_FFFF)) begin
          result_d = f3_q[1] ? 32'd0 : 32'h8000_0000;
          state_d  = ST_DONE;
        end
      end
      ST_ITER: begin
        if (!f3_q[2]) begin
          acc_d = {acc_q[62:0], 1'b0} + (b_q[bit_idx] ? {32'd0, a_q} : 64'd0);
        end else if (rem_shift >= {1'b0, b_q}) begin
          acc_d = {rem_diff, acc_q[30:0], 1'b1};
        end else begin
          acc_d = {rem_shift[31:0], acc_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER_COUNT - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = fix_result;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      f3_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign stall  = rst && ((start && (state_q == ST_IDLE)) || (state_q == ST_PREP) ||
                          (state_q == ST_ITER) || (state_q == ST_FIX));
  assign result = result_q;

endmodule
